// File: rtl/neuron_grad_backprop.sv
// neuron_grad_backprop: ReLU backward pass, one dx/dw beat per input through a shared multiplier pair.
module neuron_grad_backprop #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*WIDTH-1:0]        x_flat,
  input  logic [N*WIDTH-1:0]        w_flat,
  input  logic signed [2*WIDTH+1:0] s,
  input  logic signed [WIDTH-1:0]   dy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IW-1:0]             out_idx,
  output logic signed [2*WIDTH-1:0] out_dx,
  output logic signed [2*WIDTH-1:0] out_dw,
  output logic signed [WIDTH-1:0]   out_db,
  output logic                      out_active,
  output logic                      out_last
);
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  state_t state;
  logic signed [WIDTH-1:0] xa [N];
  logic signed [WIDTH-1:0] wa [N];
  logic signed [WIDTH-1:0] g_q, g_in, mx, mw, mg;
  logic signed [2*WIDTH-1:0] prod_dx, prod_dw;
  logic [IW-1:0] nidx;
  logic act_in, accept, step, fin, load;
  assign in_ready = (state == IDLE);
  assign act_in = (s > 0);
  assign g_in = act_in ? dy : '0;
  assign accept = in_ready && in_valid;
  assign step = (state == EMIT) && out_ready;
  assign fin = step && out_last;
  assign load = accept || (step && !out_last);
  assign nidx = (in_ready || out_last) ? '0 : out_idx + 1'b1;
  // Beat 0 comes straight from the request; later beats from the latched operands.
  assign mx = in_ready ? $signed(x_flat[WIDTH-1:0]) : xa[nidx];
  assign mw = in_ready ? $signed(w_flat[WIDTH-1:0]) : wa[nidx];
  assign mg = in_ready ? g_in : g_q;
  assign prod_dx = mg * mw;
  assign prod_dw = mg * mx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      g_q <= '0;
      for (int i = 0; i < N; i++) begin
        xa[i] <= '0;
        wa[i] <= '0;
      end
      out_valid <= 1'b0;
      out_idx <= '0;
      out_dx <= '0;
      out_dw <= '0;
      out_db <= '0;
      out_active <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (accept) begin
        state <= EMIT;
        g_q <= g_in;
        out_db <= g_in;
        out_active <= act_in;
        out_valid <= 1'b1;
        for (int i = 0; i < N; i++) begin
          xa[i] <= x_flat[i*WIDTH +: WIDTH];
          wa[i] <= w_flat[i*WIDTH +: WIDTH];
        end
      end else if (fin) begin
        state <= IDLE;
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
      if (load) begin
        out_idx <= nidx;
        out_dx <= prod_dx;
        out_dw <= prod_dw;
        out_last <= (nidx == LAST);
      end
    end
endmodule

// File: tb/tb_neuron_grad_backprop.sv
// tb_neuron_grad_backprop: directed vectors with hand-computed gradients for neuron_grad_backprop.
module tb_neuron_grad_backprop;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [31:0] x_flat = '0, w_flat = '0;
  logic signed [17:0] s = '0;
  logic signed [7:0] dy = '0, out_db;
  logic [1:0] out_idx;
  logic signed [15:0] out_dx, out_dw;
  logic out_active, out_last;
  int total = 0, bad = 0;

  neuron_grad_backprop #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_flat(x_flat), .w_flat(w_flat), .s(s), .dy(dy),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_dx(out_dx), .out_dw(out_dw), .out_db(out_db),
    .out_active(out_active), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_idx"}, out_idx, 0);
    chk({tag, "_dx"}, out_dx, 0);
    chk({tag, "_dw"}, out_dw, 0);
    chk({tag, "_db"}, out_db, 0);
    chk({tag, "_act"}, out_active, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  task automatic send(input int sv, input int dv, input int xv[4], input int wv[4]);
    @(negedge clk);
    chk("send_in_ready", in_ready, 1);
    in_valid = 1;
    s = 18'(sv);
    dy = 8'(dv);
    for (int i = 0; i < 4; i++) begin
      x_flat[i*8 +: 8] = 8'(xv[i]);
      w_flat[i*8 +: 8] = 8'(wv[i]);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  // pat[c] is out_ready for the c-th cycle after the accept.
  task automatic recv(input string t, input longint edx[4], input longint edw[4],
                      input longint edb, input logic eact, input logic [7:0] pat);
    int k = 0, c = 0;
    logic stalled = 0, hlast = 0;
    logic [1:0] hidx = '0;
    logic signed [15:0] hdx = '0, hdw = '0;
    while (k < 4 && c < 40) begin
      @(negedge clk);
      out_ready = pat[c % 8];
      c++;
      chk({t, "_valid"}, out_valid, 1);
      if (stalled) begin
        chk({t, "_hold_idx"}, out_idx, hidx);
        chk({t, "_hold_dx"}, out_dx, hdx);
        chk({t, "_hold_dw"}, out_dw, hdw);
        chk({t, "_hold_last"}, out_last, hlast);
      end
      if (!out_ready) begin
        stalled = 1; hidx = out_idx; hdx = out_dx; hdw = out_dw; hlast = out_last;
      end else begin
        stalled = 0;
        chk({t, "_idx"}, out_idx, k);
        chk({t, "_dx"}, out_dx, edx[k]);
        chk({t, "_dw"}, out_dw, edw[k]);
        chk({t, "_db"}, out_db, edb);
        chk({t, "_act"}, out_active, eact);
        chk({t, "_last"}, out_last, k == 3);
        k++;
      end
    end
    chk({t, "_beats"}, k, 4);
    @(negedge clk);
    out_ready = 0;
    chk({t, "_done_valid"}, out_valid, 0);
    chk({t, "_done_ready"}, in_ready, 1);
  endtask

  int xa[4] = '{1, -2, 3, -4};
  int wa[4] = '{5, 6, -7, 8};
  longint dx2[4] = '{15, 18, -21, 24};
  longint dw2[4] = '{3, -6, 9, -12};
  longint z[4] = '{0, 0, 0, 0};

  initial begin
    #12;
    chk_reset("por");
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      x_flat = $urandom;
      w_flat = $urandom;
      s = 18'($urandom_range(1, 500));
      dy = 8'($urandom);
    end
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk_reset("rst_async");
    in_valid = 0;
    out_ready = 0;
    repeat (3) @(negedge clk);
    chk_reset("rst_held");
    rst_n = 1;

    send(100, 3, xa, wa);
    recv("basic", dx2, dw2, 3, 1, 8'hFF);

    send(0, 5, xa, wa);
    recv("s_zero", z, z, 0, 0, 8'hFF);
    send(-7, 5, xa, wa);
    recv("s_neg", z, z, 0, 0, 8'hFF);

    send(100, 3, xa, wa);
    recv("bp", dx2, dw2, 3, 1, 8'b1011_0010);

    send(1, -128, '{127, 0, 0, 0}, '{-128, 0, 0, 0});
    recv("ext", '{16384, 0, 0, 0}, '{-16256, 0, 0, 0}, -128, 1, 8'hFF);

    send(100, 3, xa, wa);
    out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_idx", out_idx, 2);
    chk("mid_dx", out_dx, -21);
    #2 rst_n = 0;
    #1 chk_reset("mid_rst");
    out_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    send(100, 3, xa, wa);
    recv("restart", dx2, dw2, 3, 1, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule
